// File: rtl/tri_bus_arbiter_if.sv
// Bus bundle between the tester sequencers, the tri_bus_arbiter and the TRIREG enable bank.
// The arbiter takes the master view; requesters and the buffer bank take the slave view.
interface tri_bus_arbiter_if #(
  parameter int N_REQ = 4
) ();
  localparam int W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [N_REQ-1:0] req;
  logic [N_REQ-1:0] gnt;
  logic [N_REQ-1:0] en_bar;
  logic [W-1:0]     owner;
  logic             busy;
  logic             timeout;

  modport master (
    input  req,
    output gnt,
    output en_bar,
    output owner,
    output busy,
    output timeout
  );

  modport slave (
    output req,
    input  gnt,
    input  en_bar,
    input  owner,
    input  busy,
    input  timeout
  );
endinterface

// File: rtl/tri_bus_arbiter.sv
// Round-robin owner selection for one shared tristate tester line, with Hi-Z turnaround between owners.
// Define TRI_ARB_TIMEOUT_EN to force a release after MAX_HOLD drive cycles (TIMEOUT pulses on it).
module tri_bus_arbiter #(
  parameter int N_REQ      = 4,
  parameter int TURNAROUND = 1,
  parameter int MAX_HOLD   = 16
) (
  input  logic              clk,
  input  logic              rst_bar,
  tri_bus_arbiter_if.master bus
);
  localparam int W  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int WP = W + 1;
  localparam logic [N_REQ-1:0] ONE_BIT   = {{(N_REQ-1){1'b0}}, 1'b1};
  localparam logic [3:0]       TURN_LOAD = 4'(TURNAROUND - 1);

  if (N_REQ < 2 || N_REQ > 8 || TURNAROUND < 0 || TURNAROUND > 15 ||
      MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_param_check
    $error("tri_bus_arbiter: parameter out of range");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    TURN  = 2'd2
  } state_t;

  state_t           state_r;
  logic [N_REQ-1:0] gnt_r;
  logic [N_REQ-1:0] en_bar_r;
  logic [W-1:0]     owner_r;
  logic [W-1:0]     ptr_r;
  logic             busy_r;
  logic [3:0]       turn_cnt_r;

  logic [W-1:0]     ptr_next_s;
  logic [W-1:0]     pick_idx_s;
  logic             pick_found_s;
  logic [WP-1:0]    cand_s;
  logic             release_s;

`ifdef TRI_ARB_TIMEOUT_EN
  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);
  logic [7:0] hold_r;
  logic       timeout_r;
  logic       force_s;
`endif

  // Pick the first requester at or after the pointer; the lowest rotated offset wins.
  always_comb begin
    pick_found_s = 1'b0;
    pick_idx_s   = '0;
    cand_s       = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      cand_s = WP'(ptr_r) + WP'(i);
      if (cand_s >= WP'(N_REQ)) begin
        cand_s = cand_s - WP'(N_REQ);
      end else begin
        cand_s = cand_s;
      end
      if (bus.req[cand_s[W-1:0]]) begin
        pick_found_s = 1'b1;
        pick_idx_s   = cand_s[W-1:0];
      end else begin
        pick_found_s = pick_found_s;
        pick_idx_s   = pick_idx_s;
      end
    end
  end

  // Release decision and the pointer that skips past the current owner.
  always_comb begin
    if (owner_r == W'(N_REQ - 1)) begin
      ptr_next_s = '0;
    end else begin
      ptr_next_s = owner_r + W'(1);
    end
`ifdef TRI_ARB_TIMEOUT_EN
    force_s   = bus.req[owner_r] && (hold_r == HOLD_LAST);
    release_s = !bus.req[owner_r] || force_s;
`else
    release_s = !bus.req[owner_r];
`endif
  end

  // Arbitration FSM; every output is a register so EN_BAR never glitches onto the pin.
  always_ff @(posedge clk) begin
    if (!rst_bar) begin
      state_r    <= IDLE;
      gnt_r      <= '0;
      en_bar_r   <= '1;
      owner_r    <= '0;
      ptr_r      <= '0;
      busy_r     <= 1'b0;
      turn_cnt_r <= 4'd0;
`ifdef TRI_ARB_TIMEOUT_EN
      hold_r     <= 8'd0;
      timeout_r  <= 1'b0;
`endif
    end else begin
`ifdef TRI_ARB_TIMEOUT_EN
      timeout_r <= 1'b0;
`endif
      case (state_r)
        IDLE: begin
          if (pick_found_s) begin
            gnt_r    <= ONE_BIT << pick_idx_s;
            en_bar_r <= ~(ONE_BIT << pick_idx_s);
            owner_r  <= pick_idx_s;
            busy_r   <= 1'b1;
            state_r  <= DRIVE;
`ifdef TRI_ARB_TIMEOUT_EN
            hold_r   <= 8'd0;
`endif
          end else begin
            gnt_r    <= '0;
            en_bar_r <= '1;
            busy_r   <= 1'b0;
          end
        end
        DRIVE: begin
          if (release_s) begin
            gnt_r      <= '0;
            en_bar_r   <= '1;
            ptr_r      <= ptr_next_s;
            turn_cnt_r <= TURN_LOAD;
`ifdef TRI_ARB_TIMEOUT_EN
            timeout_r  <= force_s;
`endif
            if (TURNAROUND == 0) begin
              state_r <= IDLE;
              busy_r  <= 1'b0;
            end else begin
              state_r <= TURN;
              busy_r  <= 1'b1;
            end
          end else begin
`ifdef TRI_ARB_TIMEOUT_EN
            hold_r <= (hold_r == 8'hFF) ? hold_r : hold_r + 8'd1;
`endif
            busy_r <= 1'b1;
          end
        end
        TURN: begin
          if (turn_cnt_r == 4'd0) begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
          end else begin
            turn_cnt_r <= turn_cnt_r - 4'd1;
          end
        end
        default: begin
          state_r  <= IDLE;
          gnt_r    <= '0;
          en_bar_r <= '1;
          busy_r   <= 1'b0;
        end
      endcase
    end
  end

  assign bus.gnt    = gnt_r;
  assign bus.en_bar = en_bar_r;
  assign bus.owner  = owner_r;
  assign bus.busy   = busy_r;
`ifdef TRI_ARB_TIMEOUT_EN
  assign bus.timeout = timeout_r;
`else
  assign bus.timeout = 1'b0;
`endif
endmodule

// File: tb/tb_tri_bus_arbiter.sv
// Bench for tri_bus_arbiter: directed grant/release events checked through a scoreboard,
// then a random contention phase checking the enable invariant and absence of starvation.
module tb_tri_bus_arbiter;
  localparam int N  = 4;
  localparam int TA = 1;
  localparam int MH = 16;

  typedef struct {
    int         ed;
    logic [3:0] gnt;
    logic [1:0] owner;
    logic       busy;
    logic       tmo;
  } ev_t;

  ev_t  sb_q[$];
  logic clk = 1'b0;
  logic rst_bar;
  int   checks = 0;
  int   passes = 0;
  int   edge_n = 0;
  bit   ev_mode = 1'b0;
  logic [3:0] p_gnt;
  logic       p_busy;
  logic       p_tmo;

  tri_bus_arbiter_if #(.N_REQ(N)) bus ();

  tri_bus_arbiter #(.N_REQ(N), .TURNAROUND(TA), .MAX_HOLD(MH)) dut (
    .clk(clk),
    .rst_bar(rst_bar),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input bit ok, input string detail);
    checks = checks + 1;
    if (ok) passes = passes + 1;
    else $display("FAIL %s: %s", nm, detail);
  endtask

  task automatic push(input int ed, input logic [3:0] g, input logic [1:0] o,
                      input logic b, input logic t);
    ev_t e;
    e.ed = ed; e.gnt = g; e.owner = o; e.busy = b; e.tmo = t;
    sb_q.push_back(e);
  endtask

  task automatic wait_edge(input int n);
    while (edge_n < n) @(negedge clk);
  endtask

  task automatic pulse_reset();
    rst_bar = 1'b0;
    bus.req = 4'b0000;
    @(negedge clk);
    rst_bar = 1'b1;
  endtask

  // Monitor: invariants every cycle, reset values under reset, scoreboard pop on any output change
  always @(posedge clk) begin
    ev_t e;
    bit  ok;
    #1;
    edge_n = edge_n + 1;
    check("en_bar_inv", bus.en_bar === ~bus.gnt,
          $sformatf("edge %0d en_bar=%b gnt=%b", edge_n, bus.en_bar, bus.gnt));
    check("onehot0", !$isunknown(bus.en_bar) && $onehot0(~bus.en_bar),
          $sformatf("edge %0d en_bar=%b", edge_n, bus.en_bar));
`ifndef TRI_ARB_TIMEOUT_EN
    check("tmo_low", bus.timeout === 1'b0, $sformatf("edge %0d timeout=%b want 0", edge_n, bus.timeout));
`endif
    if (rst_bar === 1'b0) begin
      check("reset_state", bus.gnt === 4'b0000 && bus.en_bar === 4'b1111 && bus.owner === 2'd0 &&
            bus.busy === 1'b0 && bus.timeout === 1'b0,
            $sformatf("edge %0d gnt=%b en_bar=%b owner=%0d busy=%b tmo=%b want 0000/1111/0/0/0",
                      edge_n, bus.gnt, bus.en_bar, bus.owner, bus.busy, bus.timeout));
    end else if (ev_mode && (bus.gnt !== p_gnt || bus.busy !== p_busy || bus.timeout !== p_tmo)) begin
      if (sb_q.size() == 0) begin
        check("unexpected_event", 1'b0, $sformatf("edge %0d gnt=%b busy=%b tmo=%b with no expected event",
              edge_n, bus.gnt, bus.busy, bus.timeout));
      end else begin
        e  = sb_q.pop_front();
        ok = (edge_n == e.ed) && (bus.gnt === e.gnt) && (bus.busy === e.busy) &&
             (bus.timeout === e.tmo) && ((e.gnt == 4'b0000) || (bus.owner === e.owner));
        check("event", ok, $sformatf("got edge=%0d gnt=%b owner=%0d busy=%b tmo=%b want edge=%0d gnt=%b owner=%0d busy=%b tmo=%b",
              edge_n, bus.gnt, bus.owner, bus.busy, bus.timeout, e.ed, e.gnt, e.owner, e.busy, e.tmo));
      end
    end
    p_gnt  = bus.gnt;
    p_busy = bus.busy;
    p_tmo  = bus.timeout;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", passes, checks);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int         g;
    logic [1:0] sel;
    int         wait_cnt [4];
    int         hold_left [4];
    bit         served [4];

    // Reset held 3 edges with every request high, then the first grant goes to requester 0
    rst_bar = 1'b0;
    bus.req = 4'b1111;
    wait_edge(3);
    ev_mode = 1'b1;
    rst_bar = 1'b1;
    push(4, 4'b0001, 2'd0, 1'b1, 1'b0);
    wait_edge(4);
    bus.req = 4'b0000;
    push(5, 4'b0000, 2'd0, 1'b1, 1'b0);
    push(6, 4'b0000, 2'd0, 1'b0, 1'b0);
    wait_edge(7);

    // Single requester 2 holds for 4 drive cycles
    bus.req = 4'b0100;
    g = edge_n + 1;
    push(g, 4'b0100, 2'd2, 1'b1, 1'b0);
    wait_edge(g + 3);
    bus.req = 4'b0000;
    push(g + 4, 4'b0000, 2'd0, 1'b1, 1'b0);
    push(g + 5, 4'b0000, 2'd0, 1'b0, 1'b0);
    wait_edge(g + 6);

    // Rotation 0,1,2,3,0 with two Hi-Z cycles between owners
    pulse_reset();
    bus.req = 4'b1111;
    g = edge_n + 1;
    for (int k = 0; k < 5; k++) begin
      sel = 2'(k % 4);
      push(g, 4'b0001 << sel, sel, 1'b1, 1'b0);
      push(g + 3, 4'b0000, 2'd0, 1'b1, 1'b0);
      push(g + 4, 4'b0000, 2'd0, 1'b0, 1'b0);
      wait_edge(g + 2);
      if (k < 4) begin
        bus.req[sel] = 1'b0;
        wait_edge(g + 3);
        bus.req = 4'b1111;
      end else begin
        bus.req = 4'b0000;
      end
      g = g + 5;
    end
    wait_edge(g);

    // Requester 1 never lets go; requester 3 joins a few cycles later
    pulse_reset();
    bus.req = 4'b0010;
    g = edge_n + 1;
    push(g, 4'b0010, 2'd1, 1'b1, 1'b0);
    wait_edge(g + 4);
    bus.req = 4'b1010;
`ifdef TRI_ARB_TIMEOUT_EN
    push(g + MH, 4'b0000, 2'd0, 1'b1, 1'b1);
    push(g + MH + 1, 4'b0000, 2'd0, 1'b0, 1'b0);
    push(g + MH + 2, 4'b1000, 2'd3, 1'b1, 1'b0);
    wait_edge(g + MH + 4);
    bus.req = 4'b0000;
    push(g + MH + 5, 4'b0000, 2'd0, 1'b1, 1'b0);
    push(g + MH + 6, 4'b0000, 2'd0, 1'b0, 1'b0);
    wait_edge(g + MH + 7);
`else
    wait_edge(g + 30);
    bus.req = 4'b0000;
    push(g + 31, 4'b0000, 2'd0, 1'b1, 1'b0);
    push(g + 32, 4'b0000, 2'd0, 1'b0, 1'b0);
    wait_edge(g + 33);
`endif

    // Reset while owner 2 drives; afterwards requester 0 wins from the reset pointer
    pulse_reset();
    bus.req = 4'b0100;
    g = edge_n + 1;
    push(g, 4'b0100, 2'd2, 1'b1, 1'b0);
    wait_edge(g + 2);
    rst_bar = 1'b0;
    bus.req = 4'b0101;
    wait_edge(g + 3);
    rst_bar = 1'b1;
    push(g + 4, 4'b0001, 2'd0, 1'b1, 1'b0);
    wait_edge(g + 5);
    bus.req = 4'b0100;
    push(g + 6, 4'b0000, 2'd0, 1'b1, 1'b0);
    push(g + 7, 4'b0000, 2'd0, 1'b0, 1'b0);
    push(g + 8, 4'b0100, 2'd2, 1'b1, 1'b0);
    wait_edge(g + 9);
    bus.req = 4'b0000;
    push(g + 10, 4'b0000, 2'd0, 1'b1, 1'b0);
    push(g + 11, 4'b0000, 2'd0, 1'b0, 1'b0);
    wait_edge(g + 12);
    check("sb_drain", sb_q.size() == 0, $sformatf("%0d expected events never seen, want 0", sb_q.size()));

    // Random contention: requests held until granted, then for a short random tenure
    ev_mode = 1'b0;
    for (int i = 0; i < N; i++) begin
      sel = 2'(i);
      wait_cnt[sel] = 0; hold_left[sel] = 0; served[sel] = 1'b1;
    end
    for (int c = 0; c < 10000; c++) begin
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
        sel = 2'(i);
        if (bus.req[sel] == 1'b0) begin
          if ($urandom_range(0, 2) == 0) begin
            bus.req[sel] = 1'b1; served[sel] = 1'b0; wait_cnt[sel] = 0;
            hold_left[sel] = int'($urandom_range(1, 6));
          end
        end else if (bus.gnt[sel]) begin
          if (!served[sel]) begin
            served[sel] = 1'b1;
            check("no_starve", wait_cnt[sel] <= 100,
                  $sformatf("req %0d waited %0d cycles, want <= 100", i, wait_cnt[sel]));
          end
          if (hold_left[sel] <= 1) bus.req[sel] = 1'b0;
          else hold_left[sel] = hold_left[sel] - 1;
        end else if (!served[sel]) begin
          wait_cnt[sel] = wait_cnt[sel] + 1;
        end
      end
    end
    for (int i = 0; i < N; i++) begin
      sel = 2'(i);
      check("no_starve_end", served[sel] || wait_cnt[sel] <= 100,
            $sformatf("req %0d still waiting after %0d cycles, want <= 100", i, wait_cnt[sel]));
    end
    bus.req = 4'b0000;
    repeat (6) @(negedge clk);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
